// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_if
// Description : Requester handshakes (CPU, DMA) and external memory bus
//               shared through mem_bus_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
interface mem_bus_arbiter_if;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_gnt;
   logic        cpu_done;
   logic [7:0]  cpu_rdata;

   logic        dma_req;
   logic        dma_we;
   logic [15:0] dma_addr;
   logic [7:0]  dma_wdata;
   logic        dma_gnt;
   logic        dma_done;
   logic [7:0]  dma_rdata;

   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_cs;
   logic        mem_oe;
   logic        mem_we;

   // Arbiter side: owns the memory bus, answers both requesters.
   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  dma_req, dma_we, dma_addr, dma_wdata,
      input  mem_rdata,
      output cpu_gnt, cpu_done, cpu_rdata,
      output dma_gnt, dma_done, dma_rdata,
      output mem_addr, mem_wdata, mem_cs, mem_oe, mem_we
   );

   // Environment side: requesters and the memory device.
   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output dma_req, dma_we, dma_addr, dma_wdata,
      output mem_rdata,
      input  cpu_gnt, cpu_done, cpu_rdata,
      input  dma_gnt, dma_done, dma_rdata,
      input  mem_addr, mem_wdata, mem_cs, mem_oe, mem_we
   );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares the SM83 memory bus between CPU and OAM DMA, one
//               T1..T4 M-cycle per access, DMA priority with a run limit.
// Revision    : 1.0  initial release
// ============================================================================
module mem_bus_arbiter #(
   parameter int DMA_MAX_RUN = 4,
   parameter int WAIT_STATES = 0
) (
   input  logic               clk,
   input  logic               rst,
   mem_bus_arbiter_if.master  bus,
   output logic               busy,
   output logic               owner
);

   localparam int                 c_RUN_W    = $clog2(DMA_MAX_RUN + 1);
   localparam logic [c_RUN_W-1:0] c_RUN_MAX  = c_RUN_W'(DMA_MAX_RUN);
   localparam logic [2:0]         c_WAIT_MAX = 3'(WAIT_STATES);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T1   = 3'd1,
      S_T2   = 3'd2,
      S_T3   = 3'd3,
      S_T4   = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [2:0]         r_wait;
   logic [c_RUN_W-1:0] r_run;
   logic               r_owner;
   logic               r_we;
   logic [15:0]        r_addr;
   logic [7:0]         r_wdata;
   logic               r_cpu_done;
   logic               r_dma_done;
   logic [7:0]         r_cpu_rdata;
   logic [7:0]         r_dma_rdata;

   logic               w_arb;
   logic               w_dma_win;
   logic               w_cpu_win;
   logic               w_wait_done;

   assign w_arb       = (r_state == S_IDLE) || (r_state == S_T4);
   // CPU takes the bus once DMA has used up its run while the CPU was waiting.
   assign w_dma_win   = w_arb && bus.dma_req && !(bus.cpu_req && (r_run == c_RUN_MAX));
   assign w_cpu_win   = w_arb && bus.cpu_req && !w_dma_win;
   assign w_wait_done = (r_wait == c_WAIT_MAX);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_T4: w_state_nxt = (w_dma_win || w_cpu_win) ? S_T1 : S_IDLE;
         S_T1:         w_state_nxt = S_T2;
         S_T2:         w_state_nxt = S_T3;
         S_T3:         w_state_nxt = w_wait_done ? S_T4 : S_T3;
         default:      w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_wait      <= '0;
         r_run       <= '0;
         r_owner     <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cpu_done  <= 1'b0;
         r_dma_done  <= 1'b0;
         r_cpu_rdata <= '0;
         r_dma_rdata <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait     <= ((r_state == S_T3) && !w_wait_done) ? r_wait + 3'd1 : 3'd0;
         r_cpu_done <= (r_state == S_T4) && !r_owner;
         r_dma_done <= (r_state == S_T4) && r_owner;

         if (r_state == S_T4) begin
            if (r_owner) r_dma_rdata <= bus.mem_rdata;
            else         r_cpu_rdata <= bus.mem_rdata;
         end

         // The bus is driven from these copies so requesters may move on after gnt.
         if (w_dma_win) begin
            r_owner <= 1'b1;
            r_we    <= bus.dma_we;
            r_addr  <= bus.dma_addr;
            r_wdata <= bus.dma_wdata;
         end else if (w_cpu_win) begin
            r_owner <= 1'b0;
            r_we    <= bus.cpu_we;
            r_addr  <= bus.cpu_addr;
            r_wdata <= bus.cpu_wdata;
         end

         if (w_arb) begin
            if (!bus.cpu_req || w_cpu_win)
               r_run <= '0;
            else if (w_dma_win && (r_run != c_RUN_MAX))
               r_run <= r_run + c_RUN_W'(1);
         end
      end
   end

   // Grants are combinational, so gate them while reset is held.
   assign bus.cpu_gnt   = w_cpu_win && rst;
   assign bus.dma_gnt   = w_dma_win && rst;
   assign bus.cpu_done  = r_cpu_done;
   assign bus.dma_done  = r_dma_done;
   assign bus.cpu_rdata = r_cpu_rdata;
   assign bus.dma_rdata = r_dma_rdata;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_wdata = r_wdata;
   assign bus.mem_cs    = (r_state != S_IDLE);
   assign bus.mem_oe    = !r_we && ((r_state == S_T2) || (r_state == S_T3) || (r_state == S_T4));
   assign bus.mem_we    = r_we && ((r_state == S_T2) || (r_state == S_T3));
   assign busy          = (r_state != S_IDLE);
   assign owner         = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_bus_arbiter
// Description : Drives a zero-wait and a two-wait arbiter with identical
//               requests and compares both against an M-cycle level model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;

   localparam int MAXRUN = 4;
   localparam int W0     = 0;
   localparam int W2     = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        creq, cwe, dreq, dwe;
   logic [15:0] caddr, daddr;
   logic [7:0]  cwdata, dwdata;
   logic        busy0, owner0, busy2, owner2;

   always #5 clk = ~clk;

   mem_bus_arbiter_if bif0 ();
   mem_bus_arbiter_if bif2 ();

   function automatic logic [7:0] rd_fn(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h6F;
   endfunction

   assign bif0.cpu_req = creq;   assign bif2.cpu_req = creq;
   assign bif0.cpu_we = cwe;     assign bif2.cpu_we = cwe;
   assign bif0.cpu_addr = caddr; assign bif2.cpu_addr = caddr;
   assign bif0.cpu_wdata = cwdata; assign bif2.cpu_wdata = cwdata;
   assign bif0.dma_req = dreq;   assign bif2.dma_req = dreq;
   assign bif0.dma_we = dwe;     assign bif2.dma_we = dwe;
   assign bif0.dma_addr = daddr; assign bif2.dma_addr = daddr;
   assign bif0.dma_wdata = dwdata; assign bif2.dma_wdata = dwdata;
   assign bif0.mem_rdata = rd_fn(bif0.mem_addr);
   assign bif2.mem_rdata = rd_fn(bif2.mem_addr);

   mem_bus_arbiter #(.DMA_MAX_RUN(MAXRUN), .WAIT_STATES(W0)) dut0 (
      .clk(clk), .rst(rst), .bus(bif0), .busy(busy0), .owner(owner0));
   mem_bus_arbiter #(.DMA_MAX_RUN(MAXRUN), .WAIT_STATES(W2)) dut2 (
      .clk(clk), .rst(rst), .bus(bif2), .busy(busy2), .owner(owner2));

   // Model: an access is "active" for m_len cycles; m_el counts cycles into it.
   int          m_len [2] = '{4 + W0, 4 + W2};
   bit          m_act [2];
   int          m_el  [2];
   bit          m_own [2];
   bit          m_we  [2];
   logic [15:0] m_addr[2];
   logic [7:0]  m_wd  [2];
   logic [7:0]  m_crd [2];
   logic [7:0]  m_drd [2];
   bit          m_cd  [2];
   bit          m_dd  [2];
   int          m_run [2];

   int    n_vec = 0;
   int    n_err = 0;
   int    cyc   = 0;
   bit    rec_lat, rec_seq;
   int    t_gnt [2];
   int    t_done[2];
   string seq   [2];
   bit    og_c  [2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_act[k] = 0; m_el[k] = 0; m_own[k] = 0; m_we[k] = 0;
         m_addr[k] = '0; m_wd[k] = '0; m_crd[k] = '0; m_drd[k] = '0;
         m_cd[k] = 0; m_dd[k] = 0; m_run[k] = 0;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   // One clock cycle: inputs already driven after the falling edge.
   task automatic step();
      logic [8:0]  octl [2];
      logic [15:0] oaddr[2];
      logic [7:0]  owd  [2];
      logic [7:0]  ocrd [2];
      logic [7:0]  odrd [2];
      bit          og_d [2];
      bit          ocd  [2];
      logic [8:0]  ectl;
      bit          arb, dwin, cwin, fin;
      #1;
      if (!rst) model_reset();
      octl[0] = {bif0.mem_cs, bif0.mem_oe, bif0.mem_we, busy0, owner0,
                 bif0.cpu_gnt, bif0.dma_gnt, bif0.cpu_done, bif0.dma_done};
      octl[1] = {bif2.mem_cs, bif2.mem_oe, bif2.mem_we, busy2, owner2,
                 bif2.cpu_gnt, bif2.dma_gnt, bif2.cpu_done, bif2.dma_done};
      oaddr[0] = bif0.mem_addr;  oaddr[1] = bif2.mem_addr;
      owd[0]   = bif0.mem_wdata; owd[1]   = bif2.mem_wdata;
      ocrd[0]  = bif0.cpu_rdata; ocrd[1]  = bif2.cpu_rdata;
      odrd[0]  = bif0.dma_rdata; odrd[1]  = bif2.dma_rdata;
      og_c[0]  = bif0.cpu_gnt;   og_c[1]  = bif2.cpu_gnt;
      og_d[0]  = bif0.dma_gnt;   og_d[1]  = bif2.dma_gnt;
      ocd[0]   = bif0.cpu_done;  ocd[1]   = bif2.cpu_done;
      for (int k = 0; k < 2; k++) begin
         arb  = !m_act[k] || (m_el[k] == m_len[k] - 1);
         dwin = rst && arb && dreq && !(creq && (m_run[k] == MAXRUN));
         cwin = rst && arb && creq && !dwin;
         ectl = {m_act[k], m_act[k] && !m_we[k] && (m_el[k] >= 1),
                 m_act[k] && m_we[k] && (m_el[k] >= 1) && (m_el[k] <= m_len[k] - 2),
                 m_act[k], m_own[k], cwin, dwin, m_cd[k], m_dd[k]};
         check($sformatf("ctl%0d", k),   32'(octl[k]),  32'(ectl));
         check($sformatf("addr%0d", k),  32'(oaddr[k]), 32'(m_addr[k]));
         check($sformatf("wdata%0d", k), 32'(owd[k]),   32'(m_wd[k]));
         check($sformatf("crd%0d", k),   32'(ocrd[k]),  32'(m_crd[k]));
         check($sformatf("drd%0d", k),   32'(odrd[k]),  32'(m_drd[k]));
         if (rec_lat && t_gnt[k] < 0 && og_c[k]) t_gnt[k] = cyc;
         if (rec_lat && t_done[k] < 0 && ocd[k]) t_done[k] = cyc;
         if (rec_seq && seq[k].len() < 10) begin
            if (og_d[k]) seq[k] = {seq[k], "D"};
            else if (og_c[k]) seq[k] = {seq[k], "C"};
         end
         if (rst) begin
            fin     = m_act[k] && (m_el[k] == m_len[k] - 1);
            m_cd[k] = fin && !m_own[k];
            m_dd[k] = fin && m_own[k];
            if (fin && m_own[k])  m_drd[k] = rd_fn(m_addr[k]);
            if (fin && !m_own[k]) m_crd[k] = rd_fn(m_addr[k]);
            if (arb) begin
               if (!creq || cwin) m_run[k] = 0;
               else if (dwin && m_run[k] < MAXRUN) m_run[k]++;
               if (dwin) begin
                  m_act[k] = 1; m_el[k] = 0; m_own[k] = 1;
                  m_we[k] = dwe; m_addr[k] = daddr; m_wd[k] = dwdata;
               end else if (cwin) begin
                  m_act[k] = 1; m_el[k] = 0; m_own[k] = 0;
                  m_we[k] = cwe; m_addr[k] = caddr; m_wd[k] = cwdata;
               end else begin
                  m_act[k] = 0;
               end
            end else begin
               m_el[k]++;
            end
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      creq = 0; cwe = 0; caddr = '0; cwdata = '0;
      dreq = 0; dwe = 0; daddr = '0; dwdata = '0;
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      rec_lat = 0; rec_seq = 0;
      model_reset();
      @(negedge clk);
      for (int i = 0; i < 3; i++) step();
      rst = 1'b1;
      step();

      // CPU read of 0x0150, address moved right after the grant.
      rec_lat = 1;
      t_gnt = '{-1, -1}; t_done = '{-1, -1};
      creq = 1; cwe = 0; caddr = 16'h0150; cwdata = 8'h00;
      step();
      creq = 0; caddr = 16'hBEEF;
      for (int i = 0; i < 10; i++) step();
      rec_lat = 0;
      check("lat_w0", 32'(t_done[0] - t_gnt[0]), 32'(5));
      check("lat_w2", 32'(t_done[1] - t_gnt[1]), 32'(7));
      check("rd3e_w0", 32'(bif0.cpu_rdata), 32'h3E);
      check("rd3e_w2", 32'(bif2.cpu_rdata), 32'h3E);

      // Simultaneous requests: DMA write first, CPU follows back-to-back.
      creq = 1; cwe = 0; caddr = 16'h1234;
      dreq = 1; dwe = 1; daddr = 16'hFE00; dwdata = 8'hAA;
      step();
      dreq = 0;
      for (int i = 0; i < 6; i++) step();
      creq = 0;
      for (int i = 0; i < 10; i++) step();

      // Both requesters saturating the bus.
      seq = '{"", ""};
      rec_seq = 1;
      creq = 1; dreq = 1; dwe = 0; daddr = 16'hFE10;
      for (int i = 0; i < 100 && (seq[0].len() < 10 || seq[1].len() < 10); i++) step();
      rec_seq = 0;
      for (int k = 0; k < 2; k++) begin
         n_vec++;
         assert (seq[k] == "DDDDCDDDDC") else begin
            n_err++;
            $error("FAIL order%0d observed=%s expected=DDDDCDDDDC", k, seq[k]);
         end
      end
      idle_inputs();
      for (int i = 0; i < 10; i++) step();

      // Reset during T2 of a CPU read, request still held across release.
      creq = 1; cwe = 0; caddr = 16'h2000;
      step();
      step();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      step();
      check("regrant_w0", 32'(og_c[0]), 32'(1));
      check("regrant_w2", 32'(og_c[1]), 32'(1));
      creq = 0;
      for (int i = 0; i < 10; i++) step();

      // Random traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         creq   = 1'($urandom_range(0, 1));
         cwe    = 1'($urandom_range(0, 1));
         caddr  = 16'($urandom);
         cwdata = 8'($urandom);
         dreq   = 1'($urandom_range(0, 1));
         dwe    = 1'($urandom_range(0, 1));
         daddr  = 16'($urandom);
         dwdata = 8'($urandom);
         rst    = ($urandom_range(0, 63) != 0);
         step();
      end
      rst = 1'b1;
      idle_inputs();
      for (int i = 0; i < 10; i++) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
